// File: rtl/f_best_select.sv
// f_best_select: tracks the minimum (MODE=0) or maximum (MODE=1) IEEE-754 double
// over a NUM_CAND-sample search and reports the winning value and index.
`default_nettype none

module f_best_select #(
  parameter int NUM_CAND  = 16,
  parameter int MODE      = 0,
  localparam int IDX_WIDTH = $clog2(NUM_CAND) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [63:0]          F_value,
  input  logic                 F_value_tvalid,
  output logic [63:0]          best_value,
  output logic [IDX_WIDTH-1:0] best_idx,
  output logic                 best_tvalid,
  output logic                 busy,
  output logic                 nan_seen
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  localparam logic [IDX_WIDTH-1:0] C_LAST_IDX = IDX_WIDTH'(NUM_CAND - 1);
  localparam logic [IDX_WIDTH-1:0] C_NO_WIN   = IDX_WIDTH'(NUM_CAND);
  localparam logic [63:0]          C_QNAN     = 64'h7FF8_0000_0000_0000;
  localparam logic [63:0]          C_SIGN     = 64'h8000_0000_0000_0000;

  state_t               r_state;
  logic [IDX_WIDTH-1:0] r_count;

  logic                 r_s1_valid;
  logic [63:0]          r_s1_bits;
  logic [63:0]          r_s1_key;
  logic [IDX_WIDTH-1:0] r_s1_idx;
  logic                 r_s1_nan;

  logic                 r_have_best;
  logic [63:0]          r_run_bits;
  logic [63:0]          r_run_key;
  logic [IDX_WIDTH-1:0] r_run_idx;
  logic                 r_nan_flag;

  logic [63:0] w_norm;
  logic [63:0] w_key;
  logic        w_is_nan;
  logic        w_better;

  // Map the double onto an unsigned key whose order matches IEEE order;
  // -0.0 is folded onto +0.0 so the two compare equal.
  always_comb begin
    w_norm = (F_value[62:0] == 63'd0) ? 64'd0 : F_value;
    w_key  = w_norm[63] ? ~w_norm : (w_norm ^ C_SIGN);
  end

  assign w_is_nan = (F_value[62:52] == 11'h7FF) && (F_value[51:0] != 52'd0);
  assign w_better = (MODE != 0) ? (r_s1_key > r_run_key) : (r_s1_key < r_run_key);
  assign busy     = (r_state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_count     <= '0;
      r_s1_valid  <= 1'b0;
      r_s1_bits   <= '0;
      r_s1_key    <= '0;
      r_s1_idx    <= '0;
      r_s1_nan    <= 1'b0;
      r_have_best <= 1'b0;
      r_run_bits  <= '0;
      r_run_key   <= '0;
      r_run_idx   <= '0;
      r_nan_flag  <= 1'b0;
      best_value  <= '0;
      best_idx    <= '0;
      best_tvalid <= 1'b0;
      nan_seen    <= 1'b0;
    end else begin
      best_tvalid <= 1'b0;
      r_s1_valid  <= 1'b0;

      // Stage 2: strict compare so a tie keeps the earlier index.
      if (r_s1_valid) begin
        if (r_s1_nan) begin
          r_nan_flag <= 1'b1;
        end else if (!r_have_best || w_better) begin
          r_have_best <= 1'b1;
          r_run_bits  <= r_s1_bits;
          r_run_key   <= r_s1_key;
          r_run_idx   <= r_s1_idx;
        end
      end

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state     <= S_RUN;
            r_count     <= '0;
            r_have_best <= 1'b0;
            r_nan_flag  <= 1'b0;
          end
        end
        S_RUN: begin
          if (F_value_tvalid) begin
            r_s1_valid <= 1'b1;
            r_s1_bits  <= F_value;
            r_s1_key   <= w_key;
            r_s1_idx   <= r_count;
            r_s1_nan   <= w_is_nan;
            r_count    <= r_count + 1'b1;
            if (r_count == C_LAST_IDX) begin
              r_state <= S_FLUSH;
            end
          end
        end
        S_FLUSH: begin
          // Publish once the last candidate has cleared stage 2.
          if (!r_s1_valid) begin
            r_state     <= S_IDLE;
            best_tvalid <= 1'b1;
            nan_seen    <= r_nan_flag;
            best_value  <= r_have_best ? r_run_bits : C_QNAN;
            best_idx    <= r_have_best ? r_run_idx : C_NO_WIN;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
